// File: rtl/capi_mmio_ctrl.sv
// rtl/capi_mmio_ctrl.sv - PSL MMIO front end: parity check, internal bus re-timing, read ack with timeout
module capi_mmio_ctrl #(
    parameter int addr_width    = 24,
    parameter int mmiobus_width = 4 + addr_width + 64,
    parameter int rd_ports      = 8,
    parameter int ack_timeout   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ha_mmval,
    input  logic                     ha_mmcfg,
    input  logic                     ha_mmrnw,
    input  logic                     ha_mmdw,
    input  logic [addr_width-1:0]    ha_mmad,
    input  logic                     ha_mmadpar,
    input  logic [63:0]              ha_mmdata,
    input  logic                     ha_mmdatapar,
    output logic [mmiobus_width-1:0] o_mmiobus,
    input  logic [rd_ports-1:0]      i_rd_v,
    input  logic [64*rd_ports-1:0]   i_rd_d,
    output logic                     ah_mmack,
    output logic [63:0]              ah_mmdata,
    output logic                     ah_mmdatapar,
    output logic [2:0]               o_err
);

    typedef enum logic [2:0] {IDLE, WDATA, WACK, RWAIT, RACK} state_t;

    localparam logic [7:0] cnt_last = 8'(ack_timeout - 1);

    state_t                   state_q, state_d;
    logic [mmiobus_width-1:0] bus_q, bus_d;
    logic                     ack_q, ack_d;
    logic [63:0]              data_q, data_d;
    logic                     par_q, par_d;
    logic [2:0]               err_q, err_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     dw_q, dw_d;
    logic [63:0]              wdata_q, wdata_d;

    logic                     par_ok;
    logic                     cmd_phase;
    logic                     rd_any;
    logic                     timeout;
    logic [63:0]              rd_or;

    function automatic logic [63:0] fmt_rd(input logic [63:0] d, input logic dw);
        return dw ? d : {d[31:0], d[31:0]};
    endfunction

    // Data parity only matters for writes; reads carry no payload.
    assign par_ok    = (^{ha_mmad, ha_mmadpar}) & (ha_mmrnw | (^{ha_mmdata, ha_mmdatapar}));
    assign cmd_phase = bus_q[mmiobus_width-1];
    assign rd_any    = |i_rd_v;
    assign timeout   = (cnt_q == cnt_last);

    always_comb begin
        rd_or = '0;
        for (int k = 0; k < rd_ports; k++) begin
            if (i_rd_v[k]) rd_or = rd_or | i_rd_d[64*k +: 64];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // WACK/RACK last two cycles when the ack is built there; ack_q marks the ack cycle itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ha_mmval) begin
                    if (par_ok) state_d = ha_mmrnw ? RWAIT : WDATA;
                    else        state_d = ha_mmrnw ? RACK : WACK;
                end
            end
            WDATA:   state_d = WACK;
            WACK:    if (ack_q) state_d = IDLE;
            RWAIT:   if (!cmd_phase && (rd_any || timeout)) state_d = RACK;
            RACK:    if (ack_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_d   = '0;
        ack_d   = 1'b0;
        data_d  = '0;
        par_d   = 1'b0;
        err_d   = '0;
        cnt_d   = cnt_q;
        dw_d    = dw_q;
        wdata_d = wdata_q;
        if (ha_mmval && state_q != IDLE) err_d[2] = 1'b1;
        case (state_q)
            IDLE: begin
                if (ha_mmval) begin
                    dw_d    = ha_mmdw;
                    wdata_d = ha_mmdata;
                    cnt_d   = '0;
                    if (par_ok) bus_d = mmiobus_width'({1'b1, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, 64'h0});
                    else        err_d[0] = 1'b1;
                end
            end
            WDATA: bus_d = mmiobus_width'(wdata_q);
            WACK:  ack_d = !ack_q;
            RWAIT: begin
                if (!cmd_phase) begin
                    cnt_d = cnt_q + 8'd1;
                    if (rd_any) begin
                        ack_d  = 1'b1;
                        data_d = fmt_rd(rd_or, dw_q);
                    end else if (timeout) begin
                        ack_d    = 1'b1;
                        data_d   = '1;
                        err_d[1] = 1'b1;
                    end
                end
            end
            RACK: begin
                if (!ack_q) begin
                    ack_d  = 1'b1;
                    data_d = '1;
                end
            end
            default: ;
        endcase
        if (ack_d) par_d = ~^data_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            par_q   <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            dw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            bus_q   <= bus_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            par_q   <= par_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dw_q    <= dw_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_mmiobus    = bus_q;
    assign ah_mmack     = ack_q;
    assign ah_mmdata    = data_q;
    assign ah_mmdatapar = par_q;
    assign o_err        = err_q;

endmodule
